// File: rtl/wb_slave_responder_if.sv
// Wishbone classic-cycle handshake between one master and the responder.
interface wb_slave_responder_if;
   logic        CYC;
   logic        STB;
   logic [31:0] ADR;
   logic        ACK;

   modport master (output CYC, output STB, output ADR, input ACK);
   modport slave  (input CYC, input STB, input ADR, output ACK);
endinterface

// File: rtl/wb_slave_responder.sv
// Wishbone classic slave: address-window decode, programmable wait states,
// single-cycle registered ACK, transfer counter and sticky abort flag.
module wb_slave_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
   parameter logic [31:0] ADR_MASK    = 32'hFFFF_0000,
   parameter int          CNT_W       = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   wb_slave_responder_if.slave  wb,
   output logic                 busy,
   output logic [31:0]          last_adr,
   output logic [CNT_W-1:0]     xfer_count,
   output logic                 abort_flag,
   input  logic                 clr_flags
);

   localparam logic [3:0] WS = WAIT_STATES[3:0];

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       ack_q, busy_q;
   logic       req, hit;
   logic       accept, done, abort;

   assign req = wb.CYC & wb.STB;
   assign hit = ((wb.ADR & ADR_MASK) == BASE_ADR);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            if (req && hit) begin
               accept = 1'b1;
               if (WS == 4'd0) begin
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
                  cnt_n   = WS;
               end
            end
         end
         WAIT: begin
            // Master withdrawing before ACK is an abort; ADR is not re-decoded here.
            if (!req) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else if (cnt <= 4'd1) begin
               state_n = RESP;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP: begin
            // Always return to IDLE so a held request re-arbitrates one cycle later.
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         last_adr   <= 32'h0;
         xfer_count <= '0;
         abort_flag <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         ack_q  <= (state_n == RESP);
         busy_q <= (state_n != IDLE);
         if (accept)
            last_adr <= wb.ADR;
         // Clear has priority over a same-cycle increment or abort.
         if (clr_flags) begin
            xfer_count <= '0;
            abort_flag <= 1'b0;
         end else begin
            if (done)
               xfer_count <= xfer_count + CNT_W'(1);
            if (abort)
               abort_flag <= 1'b1;
         end
      end
   end

   assign wb.ACK = ack_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_wb_slave_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one master stimulus.
module tb_wb_slave_responder;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, clr = 1'b0;
   logic [31:0] adr = 32'h0;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   wb_slave_responder_if if0 ();
   wb_slave_responder_if if1 ();
   wb_slave_responder_if if3 ();
   assign if0.CYC = cyc; assign if0.STB = stb; assign if0.ADR = adr;
   assign if1.CYC = cyc; assign if1.STB = stb; assign if1.ADR = adr;
   assign if3.CYC = cyc; assign if3.STB = stb; assign if3.ADR = adr;

   logic        busy0, busy1, busy3;
   logic [31:0] last0, last1, last3;
   logic [3:0]  cnt0;
   logic [15:0] cnt1, cnt3;
   logic        abort0, abort1, abort3;

   wb_slave_responder #(.WAIT_STATES(0), .CNT_W(4)) u0 (
      .CLK(CLK), .RST(RST), .wb(if0), .busy(busy0), .last_adr(last0),
      .xfer_count(cnt0), .abort_flag(abort0), .clr_flags(clr));
   wb_slave_responder #(.WAIT_STATES(1)) u1 (
      .CLK(CLK), .RST(RST), .wb(if1), .busy(busy1), .last_adr(last1),
      .xfer_count(cnt1), .abort_flag(abort1), .clr_flags(clr));
   wb_slave_responder #(.WAIT_STATES(3)) u3 (
      .CLK(CLK), .RST(RST), .wb(if3), .busy(busy3), .last_adr(last3),
      .xfer_count(cnt3), .abort_flag(abort3), .clr_flags(clr));

   typedef struct packed {
      logic        cyc, stb, clr;
      logic [31:0] adr;
      logic        ack, busy, abort;
      logic [15:0] cnt;
      logic [31:0] last;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic c, input logic s, input logic [31:0] a, input logic k);
      cyc = c; stb = s; adr = a; clr = k;
   endtask

   // Idle long enough for every instance to settle in IDLE, then clear flags.
   task automatic settle();
      drive(0, 0, 32'h0, 0);
      repeat (5) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int pulses;
      logic prev_ack;

      // Table for the 1-wait-state instance: inputs before a posedge, outputs after it.
      //            cyc stb clr adr            ack busy abt cnt    last
      vt[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,16'd0,32'h00};
      vt[1]  = '{1'b1,1'b1,1'b0,32'h10,       1'b0,1'b1,1'b0,16'd0,32'h10};
      vt[2]  = '{1'b1,1'b1,1'b0,32'h10,       1'b1,1'b1,1'b0,16'd0,32'h10};
      vt[3]  = '{1'b0,1'b0,1'b0,32'h10,       1'b0,1'b0,1'b0,16'd1,32'h10};
      vt[4]  = '{1'b1,1'b1,1'b0,32'h20,       1'b0,1'b1,1'b0,16'd1,32'h20};
      vt[5]  = '{1'b1,1'b1,1'b0,32'h30,       1'b1,1'b1,1'b0,16'd1,32'h20};
      vt[6]  = '{1'b1,1'b1,1'b0,32'h30,       1'b0,1'b0,1'b0,16'd2,32'h20};
      vt[7]  = '{1'b1,1'b1,1'b0,32'h30,       1'b0,1'b1,1'b0,16'd2,32'h30};
      vt[8]  = '{1'b0,1'b0,1'b0,32'h30,       1'b0,1'b0,1'b1,16'd2,32'h30};
      vt[9]  = '{1'b0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b0,16'd0,32'h30};
      vt[10] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,16'd0,32'h30};
      vt[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,16'd0,32'h30};
      vt[12] = '{1'b1,1'b1,1'b0,32'h0001_0000,1'b0,1'b0,1'b0,16'd0,32'h30};
      vt[13] = '{1'b1,1'b1,1'b0,32'h0001_0000,1'b0,1'b0,1'b0,16'd0,32'h30};
      vt[14] = '{1'b1,1'b1,1'b1,32'h40,       1'b0,1'b1,1'b0,16'd0,32'h40};
      vt[15] = '{1'b1,1'b1,1'b0,32'h40,       1'b1,1'b1,1'b0,16'd0,32'h40};
      vt[16] = '{1'b0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b0,16'd0,32'h40};

      // Reset state while RST is held low.
      #2;
      chk("rst_ack1", {31'h0, if1.ACK}, 32'h0);
      chk("rst_busy1", {31'h0, busy1}, 32'h0);
      chk("rst_last1", last1, 32'h0);
      chk("rst_cnt1", {16'h0, cnt1}, 32'h0);
      chk("rst_abort1", {31'h0, abort1}, 32'h0);
      chk("rst_ack0", {31'h0, if0.ACK}, 32'h0);
      chk("rst_ack3", {31'h0, if3.ACK}, 32'h0);
      #5 RST = 1'b1;

      for (int i = 0; i < 17; i++) begin
         drive(vt[i].cyc, vt[i].stb, vt[i].adr, vt[i].clr);
         tick();
         chk($sformatf("vec%0d_ack", i), {31'h0, if1.ACK}, {31'h0, vt[i].ack});
         chk($sformatf("vec%0d_busy", i), {31'h0, busy1}, {31'h0, vt[i].busy});
         chk($sformatf("vec%0d_abort", i), {31'h0, abort1}, {31'h0, vt[i].abort});
         chk($sformatf("vec%0d_cnt", i), {16'h0, cnt1}, {16'h0, vt[i].cnt});
         chk($sformatf("vec%0d_last", i), last1, vt[i].last);
      end

      // Zero wait states, request held 6 cycles: ACK on alternate cycles.
      settle();
      drive(1, 1, 32'h4, 0);
      pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("b2b_ack%0d", i), {31'h0, if0.ACK}, {31'h0, (i % 2 == 1)});
         if (if0.ACK) pulses++;
      end
      drive(0, 0, 32'h0, 0);
      chk("b2b_pulses", pulses, 32'd3);
      chk("b2b_cnt", {28'h0, cnt0}, 32'd3);
      chk("b2b_last", last0, 32'h4);

      // Out-of-window address held 10 cycles.
      settle();
      drive(1, 1, 32'h0001_0000, 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (if1.ACK || busy1) pulses++;
      end
      drive(0, 0, 32'h0, 0);
      chk("miss_ack_or_busy", pulses, 32'd0);
      chk("miss_cnt", {16'h0, cnt1}, 32'd0);
      chk("miss_last", last1, 32'h4);

      // Abort with 3 wait states, then a normal transfer, then clear.
      settle();
      drive(1, 1, 32'h50, 0);
      tick();
      chk("abt_busy_acc", {31'h0, busy3}, 32'h1);
      tick();
      stb = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (if3.ACK) pulses++;
      end
      chk("abt_no_ack", pulses, 32'd0);
      chk("abt_flag", {31'h0, abort3}, 32'h1);
      chk("abt_busy", {31'h0, busy3}, 32'h0);
      chk("abt_cnt", {16'h0, cnt3}, 32'd0);
      drive(1, 1, 32'h58, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("ws3_ack_early%0d", i), {31'h0, if3.ACK}, 32'h0);
      end
      tick();
      chk("ws3_ack", {31'h0, if3.ACK}, 32'h1);
      drive(0, 0, 32'h0, 0);  // dropping req in RESP must not abort
      tick();
      chk("ws3_ack_done", {31'h0, if3.ACK}, 32'h0);
      chk("ws3_cnt", {16'h0, cnt3}, 32'd1);
      chk("ws3_last", last3, 32'h58);
      chk("ws3_abort_sticky", {31'h0, abort3}, 32'h1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_abort", {31'h0, abort3}, 32'h0);
      chk("clr_cnt", {16'h0, cnt3}, 32'd0);

      // Counter wrap on the 4-bit instance: 16 transfers in 32 cycles.
      settle();
      drive(1, 1, 32'h8, 0);
      pulses = 0;
      prev_ack = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (if0.ACK) pulses++;
         if (if0.ACK && prev_ack) chk("wrap_no_consecutive_ack", 32'h1, 32'h0);
         prev_ack = if0.ACK;
         if (i == 30) chk("wrap_cnt15", {28'h0, cnt0}, 32'd15);
      end
      drive(0, 0, 32'h0, 0);
      chk("wrap_pulses", pulses, 32'd16);
      chk("wrap_cnt0", {28'h0, cnt0}, 32'd0);
      chk("wrap_abort", {31'h0, abort0}, 32'h0);
      chk("wrap_last", last0, 32'h8);

      // Asynchronous reset mid-WAIT (3 ws) while the 1-ws instance is in RESP.
      settle();
      drive(1, 1, 32'h60, 0);
      tick();
      tick();
      chk("prerst_busy3", {31'h0, busy3}, 32'h1);
      chk("prerst_ack1", {31'h0, if1.ACK}, 32'h1);
      #3 RST = 1'b0;
      #1;
      chk("arst_ack1", {31'h0, if1.ACK}, 32'h0);
      chk("arst_busy3", {31'h0, busy3}, 32'h0);
      chk("arst_last3", last3, 32'h0);
      chk("arst_cnt1", {16'h0, cnt1}, 32'd0);
      drive(0, 0, 32'h0, 0);
      #3 RST = 1'b1;
      drive(1, 1, 32'h70, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("postrst_ack_early%0d", i), {31'h0, if3.ACK}, 32'h0);
      end
      tick();
      chk("postrst_ack", {31'h0, if3.ACK}, 32'h1);
      drive(0, 0, 32'h0, 0);
      tick();
      chk("postrst_cnt", {16'h0, cnt3}, 32'd1);
      chk("postrst_last", last3, 32'h70);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_slave_responder.md
Name: wb_slave_responder

Overview:
- Wishbone classic-cycle slave/responder: the target end of the CYC/STB/ADR/ACK bus that BFM-driven masters initiate on.
- Decodes the address window, inserts a programmable number of wait states, and returns a single-cycle ACK.
- Tracks completed transfers and the last accepted address, and flags master-side aborts.
- Serves as the DUT for SVA unit benches on the Wishbone handshake.

Parameters:
- WAIT_STATES, 1: cycles inserted between request acceptance and ACK; legal range 0..15.
- BASE_ADR, 32'h0000_0000: decode base.
- ADR_MASK, 32'hFFFF_0000: decode mask; hit when (ADR & ADR_MASK) == BASE_ADR.
- CNT_W, 16: width of xfer_count.

Ports:
- CLK  input  1  bus clock, all state on posedge.
- RST  input  1  asynchronous, active-low reset (0 = reset).
- CYC  input  1  master cycle valid.
- STB  input  1  master strobe.
- ADR  input  32  master address.
- ACK  output  1  slave acknowledge, registered.
- busy  output  1  high while a request is accepted and not yet ACKed.
- last_adr  output  32  address latched at the most recent acceptance.
- xfer_count  output  CNT_W  number of completed (ACKed) transfers.
- abort_flag  output  1  sticky; set when the master withdraws a request before ACK.
- clr_flags  input  1  synchronous clear of abort_flag and xfer_count.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, ACK=0, busy=0, last_adr=0, xfer_count=0, abort_flag=0, wait counter=0.
- Request term: req = CYC & STB; hit = ((ADR & ADR_MASK) == BASE_ADR).
- FSM states: IDLE, WAIT, RESP.
- IDLE, req & hit sampled at posedge k:
  - latch last_adr=ADR; busy=1.
  - if WAIT_STATES==0, go to RESP; otherwise load counter=WAIT_STATES and go to WAIT.
- IDLE, req & !hit: no response ever; stay IDLE; busy=0. Master-side timeout is the master's concern.
- WAIT: counter decrements each cycle while req holds; on reaching 1 the next state is RESP.
- Latency: ACK is high exactly in the cycle after posedge k+WAIT_STATES, i.e. first seen high at posedge k+1+WAIT_STATES. ACK width is exactly 1 cycle.
- RESP: ACK=1 for one cycle, busy=1.
  - At exit: ACK=0, busy=0, xfer_count increments (wraps modulo 2^CNT_W), back to IDLE.
  - No ACK in the cycle immediately after RESP, so the minimum spacing is 2 cycles per transfer. A request still held at that posedge is treated as a new request.
- Abort: if req deasserts in WAIT, go to IDLE with busy=0. abort_flag=1 sticky, no ACK, xfer_count unchanged.
  - req deasserting in RESP does not abort; ACK still completes.
- ADR changing during WAIT is ignored; last_adr keeps the accepted value.
- clr_flags:
  - clears abort_flag and xfer_count at the next posedge.
  - if an increment or abort lands in the same cycle, the clear wins for that cycle.
  - does not disturb the FSM, ACK, busy or last_adr.
- Mid-transfer reset: immediate return to reset values, ACK dropped asynchronously, the transfer is not counted.
- CYC=1, STB=0: idle, no acceptance.
- STB=1, CYC=0: ignored.

Test Plan:
- Reset then single read, WAIT_STATES=1, ADR=32'h0000_0010, CYC=STB=1 at posedge 5 -> ACK high only during the cycle after posedge 6; xfer_count=1; last_adr=32'h0000_0010; busy high for 2 cycles.
- WAIT_STATES=0, master holds CYC=STB=1 for 6 cycles, ADR=32'h0000_0004 -> ACK pulses on alternate cycles, 3 pulses, xfer_count=3, ACK never high 2 consecutive cycles.
- Out-of-window ADR=32'h0001_0000 held 10 cycles -> ACK never asserted, busy=0, xfer_count=0, last_adr unchanged.
- WAIT_STATES=3, STB dropped 2 cycles after acceptance -> no ACK, abort_flag=1, xfer_count unchanged. Next valid request ACKs normally and abort_flag stays 1 until clr_flags pulses, after which abort_flag=0 and xfer_count=0.
- xfer_count wrap, CNT_W=4: 16 completed transfers -> xfer_count returns to 0 with no other side effect.
- RST driven low mid-WAIT (asynchronously, between clock edges) -> ACK, busy, xfer_count and last_adr are 0 immediately. After RST releases, a new request completes with the full WAIT_STATES latency.
